// File: rtl/add_pkg.sv
// Shared definitions for the bit-serial adder.
//   ADD_WIDTH_DEFAULT : default serial word length in bits
//   cnt_width()       : width of the bit-index counter for a given word length
package add_pkg;

  localparam int unsigned ADD_WIDTH_DEFAULT = 8;

  // ceil(log2(w)), never less than one bit so the counter always exists.
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned r;
    r = $clog2(w);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/add_full_adder.sv
// One-bit combinational full adder.
//   a, b : operand bits
//   cin  : carry in
//   sum  : a ^ b ^ cin
//   cout : majority(a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/add.sv
// Bit-serial adder, LSB first, one sum bit per accepted input bit.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   a, b      : operand bits (LSB first)
//   in_valid  : a/b valid this cycle
//   sof       : with in_valid, marks bit 0 of a new word
//   out       : registered sum bit
//   out_valid : out holds a new sum bit this cycle
//   last      : with out_valid, marks sum bit WIDTH-1
//   cout      : final carry of the most recent completed word
module add
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic in_valid,
  input  logic sof,
  output logic out,
  output logic out_valid,
  output logic last,
  output logic cout
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          last_q, last_d;
  logic          cout_q, cout_d;

  logic [CW-1:0] idx;
  logic          cin_eff;
  logic          fa_sum;
  logic          fa_cout;

  // sof restarts the word; counter==0 also implies a fresh word, so the
  // stored carry is ignored in both cases.
  always_comb begin
    idx     = sof ? '0 : cnt_q;
    cin_eff = (sof || (cnt_q == '0)) ? 1'b0 : carry_q;
  end

  full_adder u_fa (
    .a    (a),
    .b    (b),
    .cin  (cin_eff),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    out_d       = out_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    last_d      = 1'b0;
    if (in_valid) begin
      out_d       = fa_sum;
      out_valid_d = 1'b1;
      if (idx == LAST_IDX) begin
        last_d  = 1'b1;
        cout_d  = fa_cout;
        cnt_d   = '0;
        carry_d = 1'b0;
      end else begin
        cnt_d   = idx + CW'(1);
        carry_d = fa_cout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      cout_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      cout_q      <= cout_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign last      = last_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_add.sv
// Self-checking bench for the bit-serial adder (WIDTH = 8).
// Reference model: accumulates operand words and derives each sum bit and
// the final carry from integer addition of the partial words.
module tb_add;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, in_valid = 1'b0, sof = 1'b0;
  logic out, out_valid, last, cout;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_idx = 0;
  logic [63:0] m_a = '0, m_b = '0;
  logic        e_out = 1'b0, e_valid = 1'b0, e_last = 1'b0, e_cout = 1'b0;

  add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sof       (sof),
    .out       (out),
    .out_valid (out_valid),
    .last      (last),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_a = '0; m_b = '0;
    e_out = 1'b0; e_valid = 1'b0; e_last = 1'b0; e_cout = 1'b0;
  endtask

  task automatic model_step(input logic ia, ib, iv, isof);
    logic [64:0] s;
    if (!iv) begin
      e_valid = 1'b0;
      e_last  = 1'b0;
      return;
    end
    if (isof) m_idx = 0;
    if (m_idx == 0) begin m_a = '0; m_b = '0; end
    m_a[m_idx] = ia;
    m_b[m_idx] = ib;
    s = {1'b0, m_a} + {1'b0, m_b};
    e_out   = s[m_idx];
    e_valid = 1'b1;
    if (m_idx == W - 1) begin
      e_last = 1'b1;
      e_cout = s[W];
      m_idx  = 0;
    end else begin
      e_last = 1'b0;
      m_idx++;
    end
  endtask

  task automatic step(input logic ia, ib, iv, isof);
    @(negedge clk);
    a = ia; b = ib; in_valid = iv; sof = isof;
    @(posedge clk);
    #1;
    model_step(ia, ib, iv, isof);
    chk("out", 64'(out), 64'(e_out));
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("last", 64'(last), 64'(e_last));
    chk("cout", 64'(cout), 64'(e_cout));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0; sof = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_out", 64'(out), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_last", 64'(last), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Sends one word, optional idle cycle after bit gap_after, returns the
  // observed sum bits and final carry.
  task automatic send_word(input logic [7:0] wa, wb, input int gap_after,
                           output logic [7:0] s, output logic c);
    s = '0;
    for (int i = 0; i < W; i++) begin
      step(wa[i], wb[i], 1'b1, (i == 0));
      s[i] = out;
      if (i == gap_after) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("gap_valid", 64'(out_valid), 64'(0));
      end
    end
    c = cout;
  endtask

  initial begin
    logic [7:0] s;
    logic       c;
    logic [3:0] pat;
    logic       ra, rb, rv, rs;

    model_reset();
    #2;
    chk("por_out", 64'(out), 64'(0));
    chk("por_valid", 64'(out_valid), 64'(0));
    chk("por_cout", 64'(cout), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // single bits with sof
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      step(1'((i >> 1) & 1), 1'(i & 1), 1'b1, 1'b1);
      chk("single_out", 64'(out), 64'(pat[i]));
      chk("single_valid", 64'(out_valid), 64'(1));
    end

    // 0xFF + 0x01
    send_word(8'hFF, 8'h01, -1, s, c);
    chk("ff01_sum", 64'(s), 64'h00);
    chk("ff01_cout", 64'(c), 64'(1));

    // 0x35 + 0x4A with a gap after bit 3
    send_word(8'h35, 8'h4A, 3, s, c);
    chk("354a_sum", 64'(s), 64'h7F);
    chk("354a_cout", 64'(c), 64'(0));

    // sof with in_valid=0 is ignored; cout holds through idle
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("idle_cout", 64'(cout), 64'(0));

    // reset mid-word, then 0x01 + 0x01
    for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 1'b1, (i == 0));
    pulse_reset();
    send_word(8'h01, 8'h01, -1, s, c);
    chk("rst_word_sum", 64'(s), 64'h02);
    chk("rst_word_cout", 64'(c), 64'(0));

    // sof mid-word abandons the partial word
    for (int i = 0; i < 3; i++) step(1'b1, (i == 0), 1'b1, (i == 0));
    send_word(8'h80, 8'h80, -1, s, c);
    chk("sof_sum", 64'(s), 64'h00);
    chk("sof_cout", 64'(c), 64'(1));

    // first accepted bit after reset is bit 0 even without sof
    pulse_reset();
    for (int i = 0; i < W; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("nosof_cout", 64'(cout), 64'(1));

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      ra = 1'($urandom_range(1));
      rb = 1'($urandom_range(1));
      rv = ($urandom_range(3) != 0);
      rs = ($urandom_range(15) == 0);
      if ($urandom_range(99) == 0) pulse_reset();
      else step(ra, rb, rv, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
